// File: rtl/iob_rom_stream_reader_pkg.sv
// ============================================================================
// Module  : iob_rom_stream_reader_pkg
// Brief   : Shared FSM encoding for the ROM stream reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_rom_stream_reader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iob_rom_stream_reader_fifo.sv
// ============================================================================
// Module  : iob_rom_stream_reader_fifo
// Brief   : Small synchronous FIFO holding {last, data} with occupancy output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_rom_stream_reader_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = empty_o ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/iob_rom_stream_reader.sv
// ============================================================================
// Module  : iob_rom_stream_reader
// Brief   : Fetches len consecutive ROM words and streams them with last/done.
//           Optional running checksum: IOB_ROM_STREAM_READER_CSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_rom_stream_reader
  import iob_rom_stream_reader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int FIFO_D = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              r_en_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic              r_ready_i,
  input  logic [DATA_W-1:0] r_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum_o
`endif
);

  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int CRED_W = CNT_W + 1;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W-1:0] issued;
  logic              inflight;
  logic              inflight_last;
  logic              zero_done;
  logic              accept;
  logic              pop;
  logic              final_issue;
  logic              cmd_start;
  logic [DATA_W:0]   head;
  logic              fifo_empty;
  logic [CNT_W-1:0]  occupancy;
  logic [CRED_W-1:0] credit_use;

  assign cmd_start   = (state == ST_IDLE) && start_i;
  assign len_m1      = len - ADDR_W'(1);
  assign final_issue = (issued == len_m1);
  assign accept      = r_en_o & r_ready_i;
  assign pop         = valid_o & ready_i;

  // Slots already claimed: stored words plus the word arriving from the ROM,
  // less the slot freed by a pop in this same cycle.
  assign credit_use = {1'b0, occupancy} + CRED_W'(inflight) - CRED_W'(pop);

  assign r_en_o   = (state == ST_FETCH) && (credit_use < CRED_W'(FIFO_D));
  assign r_addr_o = base + issued;
  assign busy_o   = (state != ST_IDLE);
  assign valid_o  = ~fifo_empty;
  assign data_o   = head[DATA_W-1:0];
  assign last_o   = head[DATA_W];

  always_comb begin
    state_nx = state;
    done_o   = zero_done;
    case (state)
      ST_IDLE: begin
        if (start_i && (len_i != '0)) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (accept && final_issue) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && last_o) begin
          state_nx = ST_IDLE;
          done_o   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      base          <= '0;
      len           <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      state         <= state_nx;
      zero_done     <= cmd_start && (len_i == '0);
      inflight      <= accept;
      inflight_last <= accept && final_issue;
      if (cmd_start && (len_i != '0)) begin
        base   <= base_addr_i;
        len    <= len_i;
        issued <= '0;
      end else if (accept) begin
        issued <= issued + ADDR_W'(1);
      end
    end
  end

  iob_rom_stream_reader_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_D),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight),
    .push_data_i ({inflight_last, r_data_i}),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (occupancy)
  );

`ifdef IOB_ROM_STREAM_READER_CSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_o <= '0;
    end else if (cmd_start) begin
      csum_o <= '0;
    end else if (pop) begin
      csum_o <= csum_o + data_o;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_rom_stream_reader.sv
// ============================================================================
// Module  : tb_iob_rom_stream_reader
// Brief   : Directed bench: ROM model with ROM[a]=a, stream monitor, scenario tasks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_rom_stream_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int FIFO_D = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] len = '0;
  logic              busy, done, r_en, valid, last;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ready = 1'b1;
  logic [DATA_W-1:0] r_data = '0;
  logic [DATA_W-1:0] data;
  logic              ready = 1'b1;
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  int errors = 0;
  int checks = 0;

  iob_rom_stream_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .FIFO_D (FIFO_D)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .r_en_o      (r_en),
    .r_addr_o    (r_addr),
    .r_ready_i   (r_ready),
    .r_data_i    (r_data),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .last_o      (last)
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
    ,
    .csum_o      (csum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM port model: one-cycle synchronous read, contents equal to the address.
  always @(posedge clk) begin
    if (r_en && r_ready) r_data <= DATA_W'(r_addr);
  end

  // Port arbitration model: alternate grant cycles when alt_grant is set.
  bit alt_grant = 1'b0;
  always @(posedge clk) begin
    #1;
    if (alt_grant) r_ready = ~r_ready;
    else           r_ready = 1'b1;
  end

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] out_q[$];
  bit                last_q[$];
  int                pop_cyc_q[$];
  int done_cnt, done_misalign, addr_unstable, data_unstable, stall_cnt;
  int first_valid_cyc, start_cyc;
  bit ren_seen, busy_seen;
  bit prev_rstall, prev_ostall;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  logic [DATA_W-1:0] csum_at_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_rstall && (!r_en || r_addr !== prev_addr)) addr_unstable++;
      if (prev_ostall && (!valid || data !== prev_data || last !== prev_last)) data_unstable++;
      prev_rstall = r_en && !r_ready;
      prev_ostall = valid && !ready;
      prev_addr   = r_addr;
      prev_data   = data;
      prev_last   = last;
      if (prev_rstall) stall_cnt++;
      if (r_en && r_ready) addr_q.push_back(r_addr);
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid && ready) begin
        out_q.push_back(data);
        last_q.push_back(last);
        pop_cyc_q.push_back(cyc);
        if (done !== last) done_misalign++;
      end
      if (done) begin
        done_cnt++;
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
        csum_at_done = csum;
`endif
      end
      if (r_en) ren_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_log();
    addr_q.delete(); out_q.delete(); last_q.delete(); pop_cyc_q.delete();
    done_cnt = 0; done_misalign = 0; addr_unstable = 0; data_unstable = 0;
    stall_cnt = 0; first_valid_cyc = -1; ren_seen = 0; busy_seen = 0;
    prev_rstall = 0; prev_ostall = 0; csum_at_done = '0;
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (r_en !== 1'b0)   begin errors++; $display("FAIL reset_ren got=%b exp=0", r_en); end
    checks++; if (r_addr !== '0)   begin errors++; $display("FAIL reset_raddr got=%h exp=0", r_addr); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (last !== 1'b0)   begin errors++; $display("FAIL reset_last got=%b exp=0", last); end
    checks++; if (data !== '0)     begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
    checks++; if (csum !== '0)     begin errors++; $display("FAIL reset_csum got=%h exp=0", csum); end
`endif
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_basic();
    bit ok;
    logic [DATA_W-1:0] exp_d;
    clear_log();
    start_cmd(10'h010, 10'd4);
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (first_valid_cyc - start_cyc != 3)
      begin errors++; $display("FAIL basic_latency got=%0d exp=3", first_valid_cyc - start_cyc); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", out_q.size()); end
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 32'h10 + DATA_W'(i);
        checks++; if (out_q[i] !== exp_d) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, out_q[i], exp_d); end
        checks++; if (last_q[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, last_q[i], i == 3); end
      end
      checks++; if (pop_cyc_q[3] - pop_cyc_q[0] != 3)
        begin errors++; $display("FAIL basic_throughput got=%0d exp=3", pop_cyc_q[3] - pop_cyc_q[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_misalign != 0) begin errors++; $display("FAIL basic_done_align got=%0d exp=0", done_misalign); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
    checks++; if (csum_at_done !== 32'h46) begin errors++; $display("FAIL basic_csum got=%h exp=46", csum_at_done); end
`endif
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DATA_W-1:0] exp_d;
    clear_log();
    ready = 1'b0;
    start_cmd(10'h010, 10'd4);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (first_valid_cyc >= 0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_first_valid got=none exp=valid"); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL bp_ren_stalled got=%b exp=0", r_en); end
    checks++; if (addr_q.size() != FIFO_D) begin errors++; $display("FAIL bp_outstanding got=%0d exp=%0d", addr_q.size(), FIFO_D); end
    checks++; if (valid !== 1'b1 || data !== 32'h10) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/10", valid, data); end
    ready = 1'b1;
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", out_q.size()); end
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 32'h10 + DATA_W'(i);
        checks++; if (out_q[i] !== exp_d) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, out_q[i], exp_d); end
      end
    end
    checks++; if (data_unstable != 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", data_unstable); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_port_stall();
    bit ok;
    logic [DATA_W-1:0] exp_d;
    clear_log();
    alt_grant = 1'b1;
    start_cmd(10'h010, 10'd4);
    wait_done(60, ok);
    alt_grant = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=no_done exp=done"); end
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL stall_seen got=%0d exp=>0", stall_cnt); end
    checks++; if (addr_unstable != 0) begin errors++; $display("FAIL stall_addr_hold got=%0d exp=0", addr_unstable); end
    checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL stall_reads got=%0d exp=4", addr_q.size()); end
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", out_q.size()); end
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 32'h10 + DATA_W'(i);
        checks++; if (out_q[i] !== exp_d) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, out_q[i], exp_d); end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    clear_log();
    start_cmd(10'h3FE, 10'd4);
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    checks++; if (addr_q.size() != 4 || out_q.size() != 4)
      begin errors++; $display("FAIL wrap_count got=%0d/%0d exp=4/4", addr_q.size(), out_q.size()); end
    if (addr_q.size() == 4 && out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, addr_q[i], exp_a[i]); end
        checks++; if (out_q[i] !== DATA_W'(exp_a[i])) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, out_q[i], exp_a[i]); end
      end
      checks++; if (last_q[3] !== 1'b1) begin errors++; $display("FAIL wrap_last got=%b exp=1", last_q[3]); end
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    start_cmd(10'h055, 10'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse got=%b exp=1", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got=%b exp=0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ren_seen) begin errors++; $display("FAIL zero_ren got=1 exp=0"); end
    checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy got=1 exp=0"); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    start_cmd(10'h010, 10'd8);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (addr_q.size() >= 2) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_progress got=%0d exp=2", addr_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || r_en !== 1'b0 || valid !== 1'b0)
      begin errors++; $display("FAIL rstmid_ctrl got=busy%b ren%b valid%b exp=000", busy, r_en, valid); end
    checks++; if (r_addr !== '0 || data !== '0 || last !== 1'b0)
      begin errors++; $display("FAIL rstmid_data got=%h/%h/%b exp=0/0/0", r_addr, data, last); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", valid); end
    clear_log();
    start_cmd(10'h020, 10'd1);
    wait_done(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_restart got=no_done exp=done"); end
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL rstmid_count got=%0d exp=1", out_q.size()); end
    if (out_q.size() == 1) begin
      checks++; if (out_q[0] !== 32'h20 || last_q[0] !== 1'b1)
        begin errors++; $display("FAIL rstmid_word got=%h/%b exp=20/1", out_q[0], last_q[0]); end
    end
`ifdef IOB_ROM_STREAM_READER_CSUM_EN
    checks++; if (csum_at_done !== 32'h20) begin errors++; $display("FAIL rstmid_csum got=%h exp=20", csum_at_done); end
`endif
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_backpressure();
    test_port_stall();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
